mem_seq_ctrl: RTL and testbench
===============================

MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 128, maximum words per frame.
REQ-002 Parameter STORE_TIMEOUT, default 4, cycles allowed for mem_stored after a write.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a frame.
REQ-006 frame_len  in  8  words in the frame, latched on accepted start.
REQ-007 in_valid / in_ready  in / out  1 / 1  sample-stream handshake.
REQ-008 in_data  in  16  sample word.
REQ-009 mem_en, mem_r_w  out  1, 1  memory strobe and direction (0 = write, 1 = read).
REQ-010 mem_abus  out  8  memory address.
REQ-011 mem_din  out  16  write data to memory.
REQ-012 mem_dout  in  16  read data from memory.
REQ-013 mem_stored  in  1  memory write acknowledge.
REQ-014 out_valid / out_ready  out / in  1 / 1  readback-stream handshake.
REQ-015 out_data  out  16  readback word.
REQ-016 busy, done, err  out  1, 1, 1  frame active, one-cycle completion pulse, sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, WRITE, WAIT_ST, RB_ISSUE, RB_LAT, RB_OUT and DONE.
REQ-018 All mem_* and out_* outputs SHALL be registered.
REQ-019 IDLE: on start=1, latch len = frame_len; frame_len=0 or frame_len>DEPTH SHALL be taken as DEPTH. Clear addr and err, then go to WRITE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 WRITE: in_ready=1. On in_valid&in_ready, register mem_en=1, mem_r_w=0, mem_abus=addr, mem_din=in_data, then go to WAIT_ST.
REQ-023 WAIT_ST: in_ready=0 and mem_en=0. When mem_stored=1: addr+1; if addr was len-1, go to RB_ISSUE, otherwise go to WRITE.
REQ-024 A write SHALL take 3 cycles minimum from acceptance to the next in_ready.
REQ-025 If mem_stored stays 0 for STORE_TIMEOUT cycles in WAIT_ST, set err=1 and go to DONE; err holds until the next accepted start or reset.
REQ-026 RB_ISSUE: register mem_en=1, mem_r_w=1, mem_abus=raddr (raddr starts at 0), then go to RB_LAT.
REQ-027 RB_LAT: mem_en=0. Capture mem_dout into out_data on this edge, since memory data is valid only in the cycle after the strobe. Set out_valid=1 and go to RB_OUT.
REQ-028 RB_OUT: hold out_data and out_valid until out_ready=1. Then clear out_valid and advance raddr: if raddr was len-1, go to DONE, otherwise go to RB_ISSUE.
REQ-029 The address SHALL never wrap; the last address used is len-1 ≤ DEPTH-1.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 mem_en SHALL never be high for two consecutive cycles.

Reset
REQ-032 On reset=1 at a clock edge: state=IDLE, addr=raddr=0, len=0, and mem_en, mem_r_w, mem_abus, mem_din, in_ready, out_valid, out_data, busy, done, err all 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no further mem_en pulse and no done pulse.

Configuration
REQ-034 Macro MEM_SEQ_CTRL_READBACK_EN defined: the readback states of REQ-026 to REQ-028 are compiled in.
REQ-035 Macro MEM_SEQ_CTRL_READBACK_EN undefined: after the last write, go WAIT_ST -> DONE directly; out_valid and out_data are tied to 0 and out_ready is ignored.

Verification
REQ-036 After reset, start with frame_len=3, then feed 0x1111, 0x2222, 0x3333 with in_valid=1 and a 1-cycle mem_stored ack: writes go to addr 0,1,2, then readback gives out_data 0x1111, 0x2222, 0x3333 and one done pulse.
REQ-037 Hold out_ready=0 for 5 cycles on the second readback word: out_valid and out_data=0x2222 stay stable, and mem_en stays 0 throughout.
REQ-038 Never assert mem_stored after the first write: err=1 after 4 cycles, then a done pulse, then IDLE, with addr unchanged at 0.
REQ-039 Start with frame_len=0: exactly 128 writes occur, the last at mem_abus=0x7F, with no wrap to 0x80.
REQ-040 Assert reset during the second write's WAIT_ST: the next cycle is IDLE with busy=0, and there is no done pulse and no further mem_en pulse.
REQ-041 Pulse start in the middle of a frame: it is ignored, and the frame completes with the original length.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// Frame sequencer: writes a stream of words into memory, then optionally reads them back out.
// Define MEM_SEQ_CTRL_READBACK_EN to compile in the readback states; otherwise frames end after the last write.
//   state    | meaning
//   IDLE     | waiting for start
//   WRITE    | accepting one input word
//   WAIT_ST  | write strobe issued, waiting for mem_stored
//   RB_ISSUE | read strobe on the bus
//   RB_LAT   | read data valid, captured at end of cycle
//   RB_OUT   | readback word presented downstream
//   DONE     | one-cycle completion pulse
module mem_seq_ctrl #(
  parameter int DEPTH         = 128,
  parameter int STORE_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        mem_en,
  output logic        mem_r_w,
  output logic [7:0]  mem_abus,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_stored,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WAIT_ST, RB_ISSUE, RB_LAT, RB_OUT, DONE
  } state_t;

  localparam logic [8:0] DEPTH_L  = 9'(DEPTH);
  localparam logic [7:0] TMO_LOAD = 8'(STORE_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [8:0]  len, len_nxt;
  logic [8:0]  addr, addr_nxt;
  logic [7:0]  tmr, tmr_nxt;
  logic        err_nxt;
  logic        mem_en_nxt, mem_r_w_nxt;
  logic [7:0]  mem_abus_nxt;
  logic [15:0] mem_din_nxt;
  logic        ack;
  logic        last_wr;

  // The ack is ignored during the strobe cycle itself: this keeps a full
  // cycle between strobes and spaces accepted words at least 3 cycles apart.
  assign ack      = mem_stored && !mem_en;
  assign last_wr  = (addr == len - 9'd1);
  assign in_ready = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef MEM_SEQ_CTRL_READBACK_EN
  logic [8:0]  raddr, raddr_nxt;
  logic        out_valid_nxt;
  logic [15:0] out_data_nxt;
`else
  logic unused_rb;
  assign unused_rb = ^{mem_dout, out_ready};
  assign out_valid = 1'b0;
  assign out_data  = 16'h0000;
`endif

  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    addr_nxt     = addr;
    tmr_nxt      = tmr;
    err_nxt      = err;
    mem_en_nxt   = 1'b0;
    mem_r_w_nxt  = mem_r_w;
    mem_abus_nxt = mem_abus;
    mem_din_nxt  = mem_din;
`ifdef MEM_SEQ_CTRL_READBACK_EN
    raddr_nxt     = raddr;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (frame_len == 8'd0 || {1'b0, frame_len} > DEPTH_L) len_nxt = DEPTH_L;
          else len_nxt = {1'b0, frame_len};
          addr_nxt  = 9'd0;
          err_nxt   = 1'b0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (in_valid) begin
          mem_en_nxt   = 1'b1;
          mem_r_w_nxt  = 1'b0;
          mem_abus_nxt = addr[7:0];
          mem_din_nxt  = in_data;
          tmr_nxt      = TMO_LOAD;
          state_nxt    = WAIT_ST;
        end
      end
      WAIT_ST: begin
        if (ack) begin
          addr_nxt = addr + 9'd1;
          if (last_wr) begin
`ifdef MEM_SEQ_CTRL_READBACK_EN
            raddr_nxt    = 9'd0;
            mem_en_nxt   = 1'b1;
            mem_r_w_nxt  = 1'b1;
            mem_abus_nxt = 8'd0;
            state_nxt    = RB_ISSUE;
`else
            state_nxt    = DONE;
`endif
          end else begin
            state_nxt = WRITE;
          end
        end else if (tmr == 8'd0) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
`ifdef MEM_SEQ_CTRL_READBACK_EN
      // Read strobe registered on entry, so it is on the bus during RB_ISSUE
      // and the memory data appears during RB_LAT.
      RB_ISSUE: state_nxt = RB_LAT;
      RB_LAT: begin
        out_data_nxt  = mem_dout;
        out_valid_nxt = 1'b1;
        state_nxt     = RB_OUT;
      end
      RB_OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          raddr_nxt     = raddr + 9'd1;
          if (raddr == len - 9'd1) begin
            state_nxt = DONE;
          end else begin
            mem_en_nxt   = 1'b1;
            mem_r_w_nxt  = 1'b1;
            mem_abus_nxt = raddr_nxt[7:0];
            state_nxt    = RB_ISSUE;
          end
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len      <= 9'd0;
      addr     <= 9'd0;
      tmr      <= 8'd0;
      err      <= 1'b0;
      mem_en   <= 1'b0;
      mem_r_w  <= 1'b0;
      mem_abus <= 8'd0;
      mem_din  <= 16'h0000;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      addr     <= addr_nxt;
      tmr      <= tmr_nxt;
      err      <= err_nxt;
      mem_en   <= mem_en_nxt;
      mem_r_w  <= mem_r_w_nxt;
      mem_abus <= mem_abus_nxt;
      mem_din  <= mem_din_nxt;
    end
  end

`ifdef MEM_SEQ_CTRL_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      raddr     <= 9'd0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else begin
      raddr     <= raddr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: memory responder plus frame-level reference model (words land at 0..len-1, read back intact).
module tb_mem_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic in_valid = 1'b0, in_ready;
  logic [15:0] in_data = 16'h0;
  logic mem_en, mem_r_w;
  logic [7:0] mem_abus;
  logic [15:0] mem_din, mem_dout = 16'h0;
  logic mem_stored = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic busy, done, err;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_abus(mem_abus), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_stored(mem_stored),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  logic [15:0] mem [256];
  logic [15:0] src[$], fixed_q[$];
  logic [7:0]  wr_a[$], rd_a[$];
  logic [15:0] wr_d[$], out_q[$];
  logic [7:0]  rd_addr;
  logic [15:0] held;
  int cyc = 0, ack_cnt = 0, ack_max = 0;
  bit ack_on = 1, rd_pend = 0, prev_en = 0, prev_hold = 0;
  bit rdy_rand = 0, in_gap = 0, gap_open = 0;
  int en_viol = 0, stab_viol = 0, done_cnt = 0, out_idx = 0;
  int stall_idx = -1, stall_left = 0, stall_seen = 0, stall_en = 0;
  int acc_cyc = 0, min_gap = 1000;

  // One clock of the environment: memory responder, monitors, stream drivers.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    mem_stored = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) mem_stored = 1'b1;
    end
    if (rd_pend) begin mem_dout = mem[rd_addr]; rd_pend = 0; end
    else mem_dout = 16'($urandom);
    if (mem_en === 1'b1) begin
      if (prev_en) en_viol++;
      if (mem_r_w === 1'b0) begin
        mem[mem_abus] = mem_din;
        wr_a.push_back(mem_abus);
        wr_d.push_back(mem_din);
        if (ack_on) ack_cnt = 1 + int'($urandom_range(0, ack_max));
      end else begin
        rd_pend = 1;
        rd_addr = mem_abus;
        rd_a.push_back(mem_abus);
      end
    end
    prev_en = (mem_en === 1'b1);
    if (done === 1'b1) done_cnt++;
    if (gap_open && in_ready === 1'b1) begin
      if (cyc - acc_cyc < min_gap) min_gap = cyc - acc_cyc;
      gap_open = 0;
    end
    if (prev_hold && (out_valid !== 1'b1 || out_data !== held)) stab_viol++;
    if (out_valid === 1'b1 && out_idx == stall_idx && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
      stall_seen++;
      if (mem_en === 1'b1) stall_en++;
    end else begin
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (out_valid === 1'b1 && out_ready) begin out_q.push_back(out_data); out_idx++; end
    prev_hold = (out_valid === 1'b1) && !out_ready;
    held = out_data;
    in_valid = (src.size() > 0) && (!in_gap || $urandom_range(0, 3) != 0);
    in_data = in_valid ? src[0] : 16'($urandom);
    if (in_valid && in_ready === 1'b1) begin
      void'(src.pop_front());
      acc_cyc = cyc;
      gap_open = 1;
    end
  endtask

  task automatic clear_env();
    wr_a.delete(); wr_d.delete(); rd_a.delete(); out_q.delete(); src.delete();
    en_viol = 0; stab_viol = 0; done_cnt = 0; out_idx = 0; stall_en = 0;
    min_gap = 1000; gap_open = 0; ack_cnt = 0; ack_on = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++;
    if ({in_ready, mem_en, mem_r_w, mem_abus, mem_din, out_valid, out_data, busy, done, err} !== 46'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {in_ready, mem_en, mem_r_w, mem_abus, mem_din, out_valid, out_data, busy, done, err});
    end
    step();
    clear_env();
  endtask

  // Runs one frame; the reference is simply "exp_len words at addresses 0..exp_len-1, read back in order".
  task automatic run_frame(input string name, input logic [7:0] flen, input int exp_len,
                           input bit gap, input bit rrand, input int amax, input int poke_at);
    logic [15:0] data[$];
    int k, first_bad;
    clear_env();
    in_gap = gap; rdy_rand = rrand; ack_max = amax;
    for (int i = 0; i < exp_len; i++) begin
      if (fixed_q.size() > i) data.push_back(fixed_q[i]);
      else data.push_back(16'($urandom));
      src.push_back(data[i]);
    end
    frame_len = flen; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 6000) begin
      if (k == poke_at) begin start = 1'b1; frame_len = 8'd2; end
      else start = 1'b0;
      step();
      k++;
    end
    start = 1'b0;
    step(); step();

    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
    end
    first_bad = -1;
    for (int i = 0; i < wr_a.size() && i < exp_len; i++)
      if (first_bad < 0 && (wr_a[i] !== 8'(i) || wr_d[i] !== data[i])) first_bad = i;
    total++;
    if (wr_a.size() != exp_len || first_bad >= 0) begin
      bad++;
      $display("FAIL %s writes: got count %0d first bad index %0d, required count %0d in order from addr 0",
               name, wr_a.size(), first_bad, exp_len);
    end
`ifdef MEM_SEQ_CTRL_READBACK_EN
    first_bad = -1;
    for (int i = 0; i < out_q.size() && i < exp_len; i++)
      if (first_bad < 0 && out_q[i] !== data[i]) first_bad = i;
    total++;
    if (out_q.size() != exp_len || first_bad >= 0) begin
      bad++;
      $display("FAIL %s readback: got count %0d first bad index %0d, required count %0d matching input",
               name, out_q.size(), first_bad, exp_len);
    end
    first_bad = -1;
    for (int i = 0; i < rd_a.size(); i++)
      if (first_bad < 0 && rd_a[i] !== 8'(i)) first_bad = i;
    total++;
    if (rd_a.size() != exp_len || first_bad >= 0) begin
      bad++;
      $display("FAIL %s read_addrs: got count %0d first bad index %0d, required %0d", name, rd_a.size(), first_bad, exp_len);
    end
    total++;
    if (stab_viol !== 0) begin
      bad++;
      $display("FAIL %s out_hold: got %0d unstable cycles required 0", name, stab_viol);
    end
`else
    total++;
    if (out_q.size() != 0 || rd_a.size() != 0 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL %s no_readback: got %0d words %0d reads required 0", name, out_q.size(), rd_a.size());
    end
`endif
    total++;
    if (en_viol !== 0) begin
      bad++;
      $display("FAIL %s mem_en_back_to_back: got %0d required 0", name, en_viol);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s end_state: got busy=%b err=%b required busy=0 err=0", name, busy, err);
    end
    if (exp_len > 1) begin
      total++;
      if (min_gap < 3) begin
        bad++;
        $display("FAIL %s write_spacing: got %0d cycles required >= 3", name, min_gap);
      end
    end
  endtask

  task automatic test_basic_readback();
    fixed_q = {16'h1111, 16'h2222, 16'h3333};
    stall_idx = -1; stall_left = 0;
    run_frame("basic", 8'd3, 3, 0, 0, 0, -1);
    total++;
    if (min_gap !== 3) begin
      bad++;
      $display("FAIL basic accept_to_ready: got %0d required 3", min_gap);
    end
    fixed_q.delete();
  endtask

  task automatic test_out_stall();
    fixed_q = {16'h1111, 16'h2222, 16'h3333};
    stall_idx = 1; stall_left = 5; stall_seen = 0;
    run_frame("stall", 8'd3, 3, 0, 0, 0, -1);
`ifdef MEM_SEQ_CTRL_READBACK_EN
    total++;
    if (stall_seen !== 5 || stall_en !== 0) begin
      bad++;
      $display("FAIL stall cycles: got %0d with %0d strobes, required 5 with 0", stall_seen, stall_en);
    end
`endif
    stall_idx = -1; stall_left = 0;
    fixed_q.delete();
  endtask

  task automatic test_timeout();
    int strobe_c, err_c, done_c, k;
    clear_env();
    ack_on = 0; in_gap = 0;
    strobe_c = -1; err_c = -1; done_c = -1; k = 0;
    src = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    frame_len = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    while (done_cnt == 0 && k < 50) begin
      step();
      k++;
      if (strobe_c < 0 && wr_a.size() == 1) strobe_c = cyc;
      if (err_c < 0 && err === 1'b1) err_c = cyc;
      if (done_c < 0 && done === 1'b1) done_c = cyc;
    end
    total++;
    if (strobe_c < 0 || err_c - strobe_c !== 4 || done_c !== err_c) begin
      bad++;
      $display("FAIL timeout timing: got err at +%0d done at +%0d required +4 and +4",
               err_c - strobe_c, done_c - strobe_c);
    end
    step();
    total++;
    if (busy !== 1'b0 || err !== 1'b1 || wr_a.size() != 1 || mem_abus !== 8'h00) begin
      bad++;
      $display("FAIL timeout after: got busy=%b err=%b writes=%0d abus=%h required 0 1 1 00",
               busy, err, wr_a.size(), mem_abus);
    end
    src.delete();
    src.push_back(16'h5A5A);
    ack_on = 1; ack_max = 0; done_cnt = 0;
    frame_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout err_clear: got err=%b busy=%b required 0 1", err, busy);
    end
    k = 0;
    while (done_cnt == 0 && k < 100) begin step(); k++; end
    step(); step();
  endtask

  task automatic test_full_depth();
    run_frame("len0", 8'd0, 128, 0, 0, 0, -1);
    total++;
    if (wr_a.size() != 128 || wr_a[wr_a.size()-1] !== 8'h7F) begin
      bad++;
      $display("FAIL len0 last_addr: got count %0d required 128 ending at 7f", wr_a.size());
    end
    run_frame("over", 8'd200, 128, 1, 1, 2, -1);
  endtask

  task automatic test_reset_mid();
    int k, n;
    clear_env();
    ack_max = 0; in_gap = 0;
    for (int i = 0; i < 5; i++) src.push_back(16'($urandom));
    frame_len = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (wr_a.size() < 2 && k < 100) begin step(); k++; end
    reset = 1'b1;
    step();
    reset = 1'b0;
    src.delete();
    total++;
    if (wr_a.size() != 2 || busy !== 1'b0 || in_ready !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid idle: got writes=%0d busy=%b in_ready=%b mem_en=%b done=%b required 2 0 0 0 0",
               wr_a.size(), busy, in_ready, mem_en, done);
    end
    n = wr_a.size() + rd_a.size();
    for (int i = 0; i < 10; i++) step();
    total++;
    if (wr_a.size() + rd_a.size() != n || done_cnt !== 0) begin
      bad++;
      $display("FAIL reset_mid quiet: got strobes=%0d done=%0d required %0d 0", wr_a.size() + rd_a.size(), done_cnt, n);
    end
  endtask

  task automatic test_start_ignored();
    run_frame("poke", 8'd6, 6, 0, 0, 1, 8);
  endtask

  task automatic test_random();
    int l;
    for (int r = 0; r < 6; r++) begin
      l = int'($urandom_range(1, 20));
      run_frame($sformatf("rand%0d", r), 8'(l), l, 1, 1, 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_readback();
    test_out_stall();
    test_timeout();
    test_full_depth();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
